// File: rtl/radix4_recon_pkg.sv
// Shared definitions for the radix-4 dividend reconstructor.
//   state_t       : FSM state encoding (IDLE/CALC/ADD_R/DONE)
//   DEFAULT_WIDTH : default operand width (must be even)
//   DIGIT_W       : bits per radix-4 quotient digit
package radix4_recon_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DIGIT_W       = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    ADD_R = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/radix4_digit_mult.sv
// Radix-4 digit multiple: qd = q * d for a 2-bit digit q, built from the
// 0 / D / 2D / 3D selection so no general multiplier is needed.
//   d  : WIDTH-bit multiplicand
//   q  : radix-4 digit (0..3)
//   qd : WIDTH+2-bit product
module radix4_digit_mult
  import radix4_recon_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   d,
  input  logic [DIGIT_W-1:0] q,
  output logic [WIDTH+1:0]   qd
);

  always_comb begin
    qd = '0;
    case (q)
      2'd0:    qd = '0;
      2'd1:    qd = {2'b00, d};
      2'd2:    qd = {1'b0, d, 1'b0};
      2'd3:    qd = {1'b0, d, 1'b0} + {2'b00, d};
      default: qd = '0;
    endcase
  end

endmodule

// File: rtl/radix4_recon.sv
// Sequential radix-4 dividend reconstructor: N_out = Q*D + R.
// One quotient digit (2 bits) is consumed per cycle, MSB first, with
// acc <= 4*acc + digit*D; the remainder is added in a final cycle.
//   clk, resetn : clock, synchronous active-low reset
//   start       : request, sampled only in IDLE
//   Q, D, R     : quotient, divisor, remainder (captured on acceptance)
//   busy        : high in CALC and ADD_R
//   done        : one-cycle result-valid pulse
//   N_out       : reconstructed dividend, held until the next result
//   fits        : N_out < 2^WIDTH
//   rem_ok      : R < D (unsigned)
module radix4_recon
  import radix4_recon_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     Q,
  input  logic [WIDTH-1:0]     D,
  input  logic [WIDTH-1:0]     R,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   N_out,
  output logic                 fits,
  output logic                 rem_ok
);

  localparam int unsigned     STEPS    = WIDTH / DIGIT_W;
  localparam int unsigned     CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   q_sh;
  logic [WIDTH-1:0]   d_r;
  logic [WIDTH-1:0]   r_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] sum;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH+1:0]   qd;

  // The latched quotient is shifted left each CALC cycle so the current
  // digit is always the top two bits; this selects the same digit as
  // indexing Q[2*cnt+1:2*cnt] with a down-counting cnt.
  radix4_digit_mult #(.WIDTH(WIDTH)) u_digit_mult (
    .d  (d_r),
    .q  (q_sh[WIDTH-1 -: DIGIT_W]),
    .qd (qd)
  );

  assign sum  = acc + (2*WIDTH)'(r_r);
  assign busy = (state == CALC) || (state == ADD_R);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == '0) state_nx = ADD_R;
      ADD_R:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_sh   <= '0;
      d_r    <= '0;
      r_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      N_out  <= '0;
      fits   <= 1'b0;
      rem_ok <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_sh <= Q;
            d_r  <= D;
            r_r  <= R;
            acc  <= '0;
            cnt  <= CNT_LAST;
          end
        end
        CALC: begin
          acc  <= (acc << DIGIT_W) + (2*WIDTH)'(qd);
          q_sh <= q_sh << DIGIT_W;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ADD_R: begin
          N_out  <= sum;
          fits   <= (sum[2*WIDTH-1:WIDTH] == '0);
          rem_ok <= (r_r < d_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_recon.sv
module tb_radix4_recon;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           resetn;
  logic           start;
  logic [W-1:0]   Q, D, R;
  logic           busy, done;
  logic [2*W-1:0] N_out;
  logic           fits, rem_ok;

  always #5 clk = ~clk;

  radix4_recon #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .Q      (Q),
    .D      (D),
    .R      (R),
    .busy   (busy),
    .done   (done),
    .N_out  (N_out),
    .fits   (fits),
    .rem_ok (rem_ok)
  );

  typedef struct packed {
    logic [2*W-1:0] n;
    logic           fits;
    logic           rem_ok;
  } res_t;

  res_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  function automatic res_t model(input logic [W-1:0] q, input logic [W-1:0] d,
                                 input logic [W-1:0] r);
    res_t        e;
    int unsigned n;
    n        = int'(q) * int'(d) + int'(r);
    e.n      = n[2*W-1:0];
    e.fits   = (n < 256);
    e.rem_ok = (int'(r) < int'(d));
    return e;
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge after
  // the accepting edge.
  task automatic issue(input logic [W-1:0] q, input logic [W-1:0] d,
                       input logic [W-1:0] r);
    Q = q; D = d; R = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; edges counts rising edges since and including
  // the accepting edge.
  task automatic wait_done(output int unsigned edges, output int unsigned busy_cycles,
                           output bit timeout);
    edges = 1; busy_cycles = 0; timeout = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; Q = '0; D = '0; R = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, N_out, fits, rem_ok} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b N=%h fits=%b rem_ok=%b, expected all 0",
               busy, done, N_out, fits, rem_ok);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] tq[3] = '{8'h1C, 8'hFF, 8'h00};
    logic [W-1:0] td[3] = '{8'h05, 8'hFF, 8'h00};
    logic [W-1:0] tr[3] = '{8'h03, 8'hFF, 8'h07};
    res_t         exp_r, got;
    int unsigned  edges, bcyc;
    bit           to;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(tq[i], td[i], tr[i]));
      issue(tq[i], td[i], tr[i]);
      wait_done(edges, bcyc, to);
      exp_r = sb.pop_front();
      vectors++;
      if (to) begin
        miscompares++;
        $display("FAIL basic_timeout[%0d]: got no done, expected done within 30 cycles", i);
        continue;
      end
      got = '{N_out, fits, rem_ok};
      vectors++;
      if (got !== exp_r) begin
        miscompares++;
        $display("FAIL basic_result[%0d]: got N=%h fits=%b rem_ok=%b, expected N=%h fits=%b rem_ok=%b",
                 i, got.n, got.fits, got.rem_ok, exp_r.n, exp_r.fits, exp_r.rem_ok);
      end
      vectors++;
      if (edges !== 6 || bcyc !== 5) begin
        miscompares++;
        $display("FAIL basic_latency[%0d]: got edges=%0d busy=%0d, expected edges=6 busy=5",
                 i, edges, bcyc);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || N_out !== exp_r.n) begin
        miscompares++;
        $display("FAIL basic_pulse_hold[%0d]: got done=%b busy=%b N=%h, expected done=0 busy=0 N=%h",
                 i, done, busy, N_out, exp_r.n);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned exp_edge[$];
    int unsigned ndone = 0;
    res_t        exp_r, got;
    exp_edge = '{6, 13, 20};
    for (int k = 0; k < 3; k++) sb.push_back(model(8'h0A, 8'h0C, 8'h05));
    Q = 8'h0A; D = 8'h0C; R = 8'h05; start = 1'b1;
    for (int unsigned e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e == 3) Q = 8'h01;
      if (e == 5) Q = 8'h0A;
      if (done) begin
        ndone++;
        vectors++;
        if (exp_edge.size() == 0 || sb.size() == 0) begin
          miscompares++;
          $display("FAIL held_extra_done: got done at edge %0d, expected none", e);
        end else begin
          int unsigned ee;
          ee    = exp_edge.pop_front();
          exp_r = sb.pop_front();
          got   = '{N_out, fits, rem_ok};
          if (e !== ee || got !== exp_r) begin
            miscompares++;
            $display("FAIL held_done: got edge=%0d N=%h fits=%b rem_ok=%b, expected edge=%0d N=%h fits=%b rem_ok=%b",
                     e, got.n, got.fits, got.rem_ok, ee, exp_r.n, exp_r.fits, exp_r.rem_ok);
          end
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (ndone !== 3) begin
      miscompares++;
      $display("FAIL held_done_count: got %0d, expected 3", ndone);
    end
    sb.delete();
    @(negedge clk);
  endtask

  task automatic test_abort();
    res_t        exp_r, got;
    int unsigned edges, bcyc;
    bit          to;
    issue(8'h1C, 8'h05, 8'h03);   // accepted at edge 1
    @(negedge clk);               // after edge 2 (first CALC edge)
    resetn = 1'b0;
    @(negedge clk);               // edge 3 samples reset
    vectors++;
    if ({busy, done, N_out, fits, rem_ok} !== '0) begin
      miscompares++;
      $display("FAIL abort_state: got busy=%b done=%b N=%h fits=%b rem_ok=%b, expected all 0",
               busy, done, N_out, fits, rem_ok);
    end
    resetn = 1'b1;
    @(negedge clk);
    sb.push_back(model(8'h03, 8'h03, 8'h01));
    issue(8'h03, 8'h03, 8'h01);
    wait_done(edges, bcyc, to);
    exp_r = sb.pop_front();
    got   = '{N_out, fits, rem_ok};
    vectors++;
    if (to || got !== exp_r) begin
      miscompares++;
      $display("FAIL abort_recover: got timeout=%b N=%h fits=%b rem_ok=%b, expected N=%h fits=%b rem_ok=%b",
               to, got.n, got.fits, got.rem_ok, exp_r.n, exp_r.fits, exp_r.rem_ok);
    end
    @(negedge clk);
  endtask

  task automatic test_divider_sweep();
    logic [W-1:0] dl[7] = '{8'h40, 8'h41, 8'h7F, 8'h80, 8'hA5, 8'hFE, 8'hFF};
    res_t         exp_r, got;
    int unsigned  edges, bcyc;
    bit           to;
    int unsigned  bad = 0;
    for (int di = 0; di < 7; di++) begin
      for (int unsigned n = 0; n < 256; n++) begin
        logic [W-1:0] q, r;
        q = W'(n / int'(dl[di]));
        r = W'(n % int'(dl[di]));
        sb.push_back('{(2*W)'(n), 1'b1, 1'b1});
        issue(q, dl[di], r);
        wait_done(edges, bcyc, to);
        exp_r = sb.pop_front();
        got   = '{N_out, fits, rem_ok};
        vectors++;
        if (to || got !== exp_r) begin
          miscompares++;
          if (bad < 10)
            $display("FAIL divider_xcheck N=%0d D=%h: got timeout=%b N=%h fits=%b rem_ok=%b, expected N=%h fits=1 rem_ok=1",
                     n, dl[di], to, got.n, got.fits, got.rem_ok, exp_r.n);
          bad++;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_divider_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
